bg_deduction_engine: RTL and testbench

Parametrised background-deduction datapath for the ADQ214 post-processing chain. It replaces the flag-only background-deduction controller. For each acquisition frame it estimates a per-channel background level from the leading samples, subtracts that level from every later sample with saturation, and reports working/done status to the frame controller. It sits between the capture FIFO output and the accumulation/FFT stages.

---
 rtl/bg_deduction_engine.sv | 179 +++++++++++++++++
 tb/tb_bg_deduction_engine.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bg_deduction_engine.sv
// Background-deduction datapath: estimates a per-channel background from the
// leading samples of each frame, subtracts it from later samples with
// saturation, and reports frame status to the frame controller.
module bg_deduction_engine #(
    parameter int DATA_W  = 14,
    parameter int CH      = 2,
    parameter int BG_LOG2 = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 BG_Deduction_EN,
    input  logic                 bg_hold,
    input  logic                 data_valid_in,
    input  logic [CH*DATA_W-1:0] data_in,
    output logic [CH*DATA_W-1:0] data_out,
    output logic                 data_valid_out,
    output logic [CH*DATA_W-1:0] bg_value,
    output logic                 bg_valid,
    output logic [CH-1:0]        sat_flag,
    output logic                 short_frame,
    output logic                 PP_working,
    output logic                 BG_Deduction_Done
);

    localparam int ACC_W  = DATA_W + BG_LOG2;
    localparam int DIFF_W = DATA_W + 1;

    typedef enum logic [1:0] {IDLE, ACCUM, SUB} state_t;

    state_t                     state_q, state_d;
    logic [BG_LOG2-1:0]         cnt_q, cnt_d;
    logic signed [ACC_W-1:0]    acc_q [CH];
    logic signed [ACC_W-1:0]    acc_d [CH];
    logic signed [DATA_W-1:0]   bg_q [CH];
    logic signed [DATA_W-1:0]   bg_d [CH];
    logic                       bg_valid_q, bg_valid_d;
    logic [CH*DATA_W-1:0]       data_out_q, data_out_d;
    logic                       data_valid_out_q, data_valid_out_d;
    logic [CH-1:0]              sat_q, sat_d;
    logic                       short_q, short_d;
    logic                       pp_working_q, pp_working_d;
    logic                       done_q, done_d;
    logic                       do_sub;

    logic signed [DATA_W-1:0]   samp [CH];
    logic signed [ACC_W-1:0]    samp_ext [CH];
    logic signed [ACC_W-1:0]    acc_sum [CH];
    logic signed [DATA_W-1:0]   bg_new [CH];
    logic signed [DIFF_W-1:0]   diff [CH];
    logic [DATA_W-1:0]          sat_val [CH];
    logic [CH-1:0]              clamp;

    // Per-channel arithmetic: running sum, background (floor of sum / 2^BG_LOG2
    // taken as the upper bits), and the saturated background-deducted sample.
    for (genvar c = 0; c < CH; c++) begin : g_ch
        assign samp[c]     = data_in[c*DATA_W +: DATA_W];
        assign samp_ext[c] = {{BG_LOG2{samp[c][DATA_W-1]}}, samp[c]};
        assign acc_sum[c]  = acc_q[c] + samp_ext[c];
        assign bg_new[c]   = acc_sum[c][ACC_W-1:BG_LOG2];
        assign diff[c]     = {samp[c][DATA_W-1], samp[c]} - {bg_q[c][DATA_W-1], bg_q[c]};
        assign clamp[c]    = diff[c][DATA_W] ^ diff[c][DATA_W-1];
        assign sat_val[c]  = clamp[c] ? {diff[c][DATA_W], {(DATA_W-1){~diff[c][DATA_W]}}}
                                      : diff[c][DATA_W-1:0];
        assign bg_value[c*DATA_W +: DATA_W] = bg_q[c];
    end

    // Next-state and datapath updates for the IDLE/ACCUM/SUB frame sequence.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        acc_d            = acc_q;
        bg_d             = bg_q;
        bg_valid_d       = bg_valid_q;
        data_out_d       = data_out_q;
        data_valid_out_d = 1'b0;
        sat_d            = sat_q;
        short_d          = 1'b0;
        done_d           = 1'b0;
        do_sub           = 1'b0;
        pp_working_d     = BG_Deduction_EN & data_valid_in;

        if (!BG_Deduction_EN) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (data_valid_in) begin
                        sat_d = '0;
                        cnt_d = '0;
                        for (int c = 0; c < CH; c++) acc_d[c] = '0;
                        if (bg_hold && bg_valid_q) begin
                            state_d = SUB;
                            do_sub  = 1'b1;
                        end else begin
                            state_d = ACCUM;
                            cnt_d   = BG_LOG2'(1);
                            for (int c = 0; c < CH; c++) acc_d[c] = samp_ext[c];
                        end
                    end
                end
                ACCUM: begin
                    if (data_valid_in) begin
                        if (cnt_q == '1) begin
                            for (int c = 0; c < CH; c++) bg_d[c] = bg_new[c];
                            bg_valid_d = 1'b1;
                            state_d    = SUB;
                        end else begin
                            for (int c = 0; c < CH; c++) acc_d[c] = acc_sum[c];
                            cnt_d = cnt_q + BG_LOG2'(1);
                        end
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        short_d = 1'b1;
                    end
                end
                SUB: begin
                    if (data_valid_in) begin
                        do_sub = 1'b1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (do_sub) begin
            data_valid_out_d = 1'b1;
            for (int c = 0; c < CH; c++) begin
                data_out_d[c*DATA_W +: DATA_W] = sat_val[c];
                sat_d[c] = sat_d[c] | clamp[c];
            end
        end
    end

    // State and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            for (int c = 0; c < CH; c++) begin
                acc_q[c] <= '0;
                bg_q[c]  <= '0;
            end
            bg_valid_q       <= 1'b0;
            data_out_q       <= '0;
            data_valid_out_q <= 1'b0;
            sat_q            <= '0;
            short_q          <= 1'b0;
            pp_working_q     <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            for (int c = 0; c < CH; c++) begin
                acc_q[c] <= acc_d[c];
                bg_q[c]  <= bg_d[c];
            end
            bg_valid_q       <= bg_valid_d;
            data_out_q       <= data_out_d;
            data_valid_out_q <= data_valid_out_d;
            sat_q            <= sat_d;
            short_q          <= short_d;
            pp_working_q     <= pp_working_d;
            done_q           <= done_d;
        end
    end

    assign data_out          = data_out_q;
    assign data_valid_out    = data_valid_out_q;
    assign bg_valid          = bg_valid_q;
    assign sat_flag          = sat_q;
    assign short_frame       = short_q;
    assign PP_working        = pp_working_q;
    assign BG_Deduction_Done = done_q;

endmodule

// File: tb/tb_bg_deduction_engine.sv
// Self-checking bench for bg_deduction_engine (DATA_W=14, CH=2, BG_LOG2=2):
// directed frames followed by random frames, compared with a frame-level model.
module tb_bg_deduction_engine;

    localparam int DW    = 14;
    localparam int NCH   = 2;
    localparam int BL    = 2;
    localparam int NLEAD = 4;
    localparam int VMAX  = 8191;
    localparam int VMIN  = -8192;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              en = 1'b0;
    logic              hold = 1'b0;
    logic              vin = 1'b0;
    logic [NCH*DW-1:0] din = '0;
    logic [NCH*DW-1:0] data_out;
    logic              data_valid_out;
    logic [NCH*DW-1:0] bg_value;
    logic              bg_valid;
    logic [NCH-1:0]    sat_flag;
    logic              short_frame;
    logic              PP_working;
    logic              BG_Deduction_Done;

    int checks = 0;
    int errors = 0;

    // Frame-level reference model state
    bit     m_in_frame = 0;
    bit     m_est = 0;
    int     m_idx = 0;
    int     m_sum [NCH];
    int     m_bg [NCH];
    int     m_out [NCH];
    bit     m_bg_valid = 0;
    bit [NCH-1:0] m_sat = '0;
    bit     m_dvo = 0, m_done = 0, m_short = 0, m_pp = 0;
    int     cur_x [NCH];

    always #5 clk = ~clk;

    bg_deduction_engine #(.DATA_W(DW), .CH(NCH), .BG_LOG2(BL)) dut (
        .clk               (clk),
        .rst               (rst),
        .BG_Deduction_EN   (en),
        .bg_hold           (hold),
        .data_valid_in     (vin),
        .data_in           (din),
        .data_out          (data_out),
        .data_valid_out    (data_valid_out),
        .bg_value          (bg_value),
        .bg_valid          (bg_valid),
        .sat_flag          (sat_flag),
        .short_frame       (short_frame),
        .PP_working        (PP_working),
        .BG_Deduction_Done (BG_Deduction_Done)
    );

    function automatic logic [DW-1:0] lo14(input int v);
        return v[DW-1:0];
    endfunction

    function automatic int floorDiv(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic modelStep();
        int d;
        m_done  = 0;
        m_short = 0;
        m_dvo   = 0;
        m_pp    = en && vin;
        if (!en) begin
            m_in_frame = 0;
        end else if (vin) begin
            if (!m_in_frame) begin
                m_in_frame = 1;
                m_idx = 0;
                m_sat = '0;
                for (int c = 0; c < NCH; c++) m_sum[c] = 0;
                m_est = !(hold && m_bg_valid);
            end
            if (m_est) begin
                for (int c = 0; c < NCH; c++) m_sum[c] += cur_x[c];
                m_idx++;
                if (m_idx == NLEAD) begin
                    for (int c = 0; c < NCH; c++) m_bg[c] = floorDiv(m_sum[c], NLEAD);
                    m_bg_valid = 1;
                    m_est = 0;
                end
            end else begin
                for (int c = 0; c < NCH; c++) begin
                    d = cur_x[c] - m_bg[c];
                    if (d > VMAX) begin d = VMAX; m_sat[c] = 1; end
                    else if (d < VMIN) begin d = VMIN; m_sat[c] = 1; end
                    m_out[c] = d;
                end
                m_dvo = 1;
            end
        end else if (m_in_frame) begin
            m_done = 1;
            m_short = m_est;
            m_in_frame = 0;
        end
    endtask

    task automatic checkAll();
        checkOutput("dvo", 64'(data_valid_out), 64'(m_dvo));
        checkOutput("done", 64'(BG_Deduction_Done), 64'(m_done));
        checkOutput("short", 64'(short_frame), 64'(m_short));
        checkOutput("pp_working", 64'(PP_working), 64'(m_pp));
        checkOutput("bg_valid", 64'(bg_valid), 64'(m_bg_valid));
        checkOutput("bg_value", 64'(bg_value), 64'({lo14(m_bg[1]), lo14(m_bg[0])}));
        checkOutput("sat_flag", 64'(sat_flag), 64'(m_sat));
        if (m_dvo) begin
            checkOutput("dout0", 64'(data_out[DW-1:0]), 64'(lo14(m_out[0])));
            checkOutput("dout1", 64'(data_out[2*DW-1:DW]), 64'(lo14(m_out[1])));
        end
    endtask

    task automatic applyStimulus(input bit e, input bit v, input bit h, input int x0, input int x1);
        en = e;
        vin = v;
        hold = h;
        cur_x[0] = x0;
        cur_x[1] = x1;
        din = {lo14(x1), lo14(x0)};
        @(posedge clk);
        #1;
        modelStep();
        checkAll();
    endtask

    task automatic doReset();
        rst = 1'b1;
        #2;
        m_in_frame = 0;
        m_est = 0;
        m_bg_valid = 0;
        m_sat = '0;
        m_dvo = 0; m_done = 0; m_short = 0; m_pp = 0;
        for (int c = 0; c < NCH; c++) begin
            m_bg[c] = 0;
            m_out[c] = 0;
        end
        checkAll();
        checkOutput("rst_dout", 64'(data_out), 64'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic int rndSample();
        if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 16383)) - 8192;
        return int'($urandom_range(0, 400)) - 200;
    endfunction

    initial begin
        for (int c = 0; c < NCH; c++) begin
            m_sum[c] = 0; m_bg[c] = 0; m_out[c] = 0; cur_x[c] = 0;
        end

        doReset();

        // Basic deduction
        applyStimulus(1, 1, 0, 100, 0);
        applyStimulus(1, 1, 0, 102, 0);
        applyStimulus(1, 1, 0, 98, 0);
        applyStimulus(1, 1, 0, 100, 0);
        applyStimulus(1, 1, 0, 1100, 50);
        checkOutput("basic_out", 64'(data_out), 64'({lo14(50), lo14(1000)}));
        checkOutput("basic_bg", 64'(bg_value), 64'({lo14(0), lo14(100)}));
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("basic_done", 64'(BG_Deduction_Done), 64'd1);
        applyStimulus(1, 0, 0, 0, 0);

        // Negative rounding toward -inf
        applyStimulus(1, 1, 0, -1, 3);
        applyStimulus(1, 1, 0, -1, -7);
        applyStimulus(1, 1, 0, -1, 2);
        applyStimulus(1, 1, 0, -2, 0);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("neg_round_out", 64'(data_out[DW-1:0]), 64'(lo14(2)));
        applyStimulus(1, 0, 0, 0, 0);

        // Saturation, then clearing of sat_flag by the next frame's first sample
        for (int i = 0; i < NLEAD; i++) applyStimulus(1, 1, 0, -8000, 0);
        applyStimulus(1, 1, 0, 8000, 0);
        checkOutput("sat_out", 64'(data_out[DW-1:0]), 64'(lo14(8191)));
        checkOutput("sat_flag0", 64'(sat_flag[0]), 64'd1);
        applyStimulus(1, 0, 0, 0, 0);

        // Short frame (also clears sat_flag at its first sample)
        applyStimulus(1, 1, 0, 5, 5);
        checkOutput("sat_cleared", 64'(sat_flag), 64'd0);
        applyStimulus(1, 1, 0, 5, 5);
        applyStimulus(1, 1, 0, 5, 5);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("short_pulse", 64'(short_frame), 64'd1);
        checkOutput("short_bg_kept", 64'(bg_value), 64'({lo14(0), lo14(-8000)}));
        applyStimulus(1, 0, 0, 0, 0);

        // Hold mode: second frame reuses stored background
        for (int i = 0; i < NLEAD; i++) applyStimulus(1, 1, 0, 100, 20);
        applyStimulus(1, 1, 0, 150, 25);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 700, 40);
        checkOutput("hold_first_out", 64'(data_out[DW-1:0]), 64'(lo14(600)));
        checkOutput("hold_first_dvo", 64'(data_valid_out), 64'd1);
        applyStimulus(1, 1, 0, 800, 41);
        applyStimulus(1, 1, 1, 900, 42);
        applyStimulus(1, 0, 0, 0, 0);

        // EN dropped mid-SUB
        for (int i = 0; i < NLEAD; i++) applyStimulus(1, 1, 0, 300, -300);
        applyStimulus(1, 1, 0, 310, -290);
        applyStimulus(1, 1, 0, 320, -280);
        applyStimulus(0, 1, 0, 330, -270);
        checkOutput("abort_no_done", 64'(BG_Deduction_Done), 64'd0);
        checkOutput("abort_bg_kept", 64'(bg_value), 64'({lo14(-300), lo14(300)}));
        applyStimulus(1, 0, 0, 0, 0);

        // Reset mid-ACCUM, then a full re-estimate
        applyStimulus(1, 1, 0, 11, 12);
        applyStimulus(1, 1, 0, 13, 14);
        doReset();
        for (int i = 0; i < NLEAD; i++) applyStimulus(1, 1, 1, 40 + i, -40 - i);
        applyStimulus(1, 1, 0, 1000, -1000);
        applyStimulus(1, 0, 0, 0, 0);

        // Random frames with random hold, occasional EN aborts and short gaps
        for (int f = 0; f < 40; f++) begin
            int  len;
            bit  h;
            bit  abort;
            len   = int'($urandom_range(1, 10));
            h     = bit'($urandom_range(0, 1));
            abort = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < len; i++) begin
                applyStimulus(!(abort && i == len - 1), 1, (i == 0) ? h : bit'($urandom_range(0, 1)),
                              rndSample(), rndSample());
            end
            for (int g = 0; g < int'($urandom_range(1, 3)); g++) applyStimulus(1, 0, 0, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
